// File: rtl/rle_stream_scheduler_if.sv
// Signal bundle between the RLE scheduler, the QSPI instruction reader and video timing.
// The scheduler takes the slave view; the driving side (timing/reader/bench) takes master.
interface rle_stream_scheduler_if;
  logic        frame_start;
  logic        display_on;
  logic [19:0] instr_in;
  logic        instr_valid;
  logic        qspi_active;
  logic        flash_rst_n;
  logic        stream_hold;
  logic [5:0]  pixel_rgb;
  logic        underflow;
  logic        overflow;
  logic        frame_done;

  modport master (
    output frame_start, display_on, instr_in, instr_valid, qspi_active,
    input  flash_rst_n, stream_hold, pixel_rgb, underflow, overflow, frame_done
  );

  modport slave (
    input  frame_start, display_on, instr_in, instr_valid, qspi_active,
    output flash_rst_n, stream_hold, pixel_rgb, underflow, overflow, frame_done
  );
endinterface

// File: rtl/rle_stream_scheduler.sv
// Per-frame sequencer for the QSPI run-length instruction stream: restarts the reader,
// buffers instructions in a small FIFO and expands runs into one RGB222 pixel per clock.
module rle_stream_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HOLD_LEVEL = 3,
  parameter int unsigned RST_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  rle_stream_scheduler_if.slave bus
);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned RstW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StRestart, StPrime, StRun, StEofWait} state_e;

  state_e             state_q, state_d;
  logic [19:0]        mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [RstW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [13:0]        run_cnt_q, run_cnt_d;
  logic [5:0]         colour_q, colour_d, rgb_q, rgb_d;
  logic [6:0]         quiet_q, quiet_d;
  logic               uf_q, uf_d, of_q, of_d, done_q, done_d;
  logic               flash_prev_q, disp_prev_q;
  logic               flash_on, fifo_empty, fifo_full, write_req, push, pop;
  logic [19:0]        head;

  assign flash_on   = (state_q == StPrime) || (state_q == StRun);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];
  // The reader needs one cycle out of reset before its strobes are trusted.
  assign write_req  = bus.instr_valid && flash_on && flash_prev_q;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    run_cnt_d = run_cnt_q;
    colour_d  = colour_q;
    rgb_d     = '0;
    done_d    = 1'b0;
    uf_d      = uf_q;
    of_d      = of_q;
    quiet_d   = '0;
    pop       = 1'b0;
    push      = 1'b0;

    unique case (state_q)
      StIdle: ;
      StRestart: begin
        if (rst_cnt_q == RstW'(RST_CYCLES - 1)) state_d = StPrime;
        else rst_cnt_d = rst_cnt_q + RstW'(1);
      end
      StPrime: begin
        if (count_q >= CntW'(2) || (bus.display_on && !disp_prev_q)) state_d = StRun;
      end
      StRun: begin
        // Counter and colour hold through blanking so runs span display_on gaps.
        if (bus.display_on) begin
          if (run_cnt_q == '0) begin
            if (fifo_empty) begin
              uf_d = 1'b1;
            end else begin
              pop = 1'b1;
              if (head[13:0] == '0) begin
                done_d  = 1'b1;
                state_d = StEofWait;
              end else begin
                colour_d  = head[19:14];
                run_cnt_d = head[13:0] - 14'd1;
                rgb_d     = head[19:14];
              end
            end
          end else begin
            rgb_d     = colour_q;
            run_cnt_d = run_cnt_q - 14'd1;
          end
        end
      end
      StEofWait: ;
      default: state_d = StIdle;
    endcase

    push = write_req && (!fifo_full || pop);
    if (write_req && fifo_full && !pop) of_d = 1'b1;

    // Reader silent for more than 64 cycles while streaming counts as starvation.
    if (flash_on && !bus.qspi_active) begin
      if (quiet_q == 7'd64) begin
        quiet_d = quiet_q;
        uf_d    = 1'b1;
      end else begin
        quiet_d = quiet_q + 7'd1;
      end
    end

    wr_ptr_d = wr_ptr_q + AddrW'(push);
    rd_ptr_d = rd_ptr_q + AddrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);

    if (bus.frame_start) begin
      state_d   = StRestart;
      rst_cnt_d = '0;
      run_cnt_d = '0;
      colour_d  = '0;
      rgb_d     = '0;
      done_d    = 1'b0;
      uf_d      = 1'b0;
      of_d      = 1'b0;
      quiet_d   = '0;
      pop       = 1'b0;
      push      = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rst_cnt_q    <= '0;
      run_cnt_q    <= '0;
      colour_q     <= '0;
      rgb_q        <= '0;
      quiet_q      <= '0;
      uf_q         <= 1'b0;
      of_q         <= 1'b0;
      done_q       <= 1'b0;
      flash_prev_q <= 1'b0;
      disp_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rst_cnt_q    <= rst_cnt_d;
      run_cnt_q    <= run_cnt_d;
      colour_q     <= colour_d;
      rgb_q        <= rgb_d;
      quiet_q      <= quiet_d;
      uf_q         <= uf_d;
      of_q         <= of_d;
      done_q       <= done_d;
      flash_prev_q <= flash_on;
      disp_prev_q  <= bus.display_on;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.instr_in;
  end

  assign bus.flash_rst_n = flash_on;
  assign bus.stream_hold = (count_q >= CntW'(HOLD_LEVEL));
  assign bus.pixel_rgb   = rgb_q;
  assign bus.underflow   = uf_q;
  assign bus.overflow    = of_q;
  assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_rle_stream_scheduler.sv
// Bench for rle_stream_scheduler: queue-based frame model checked every cycle, plus
// directed frames with literal pixel/flag expectations.
module tb_rle_stream_scheduler;
  localparam int unsigned Depth     = 4;
  localparam int unsigned HoldLevel = 3;
  localparam int unsigned RstCycles = 2;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;

  rle_stream_scheduler_if bus ();

  rle_stream_scheduler #(
    .FIFO_DEPTH(Depth),
    .HOLD_LEVEL(HoldLevel),
    .RST_CYCLES(RstCycles)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame model ----------------
  typedef enum int {MIdle, MRestart, MPrime, MRun, MEof} mphase_e;
  mphase_e     ph;
  logic [19:0] mq[$];
  int          run_left, rst_left, quiet;
  logic [5:0]  colour;
  logic        fl_prev, disp_prev, model_live;
  logic        e_flash, e_hold, e_uf, e_of, e_done;
  logic [5:0]  e_rgb;

  task automatic model_step();
    logic fl_now, accept;
    logic [19:0] h;
    if (!rst_n) begin
      ph = MIdle; mq.delete(); run_left = 0; rst_left = 0; quiet = 0; colour = '0;
      fl_prev = 0; disp_prev = 0; e_uf = 0; e_of = 0; e_done = 0; e_rgb = '0;
    end else begin
      fl_now = (ph == MPrime) || (ph == MRun);
      accept = bus.instr_valid && fl_now && fl_prev;
      e_rgb  = '0;
      e_done = 0;
      if (bus.frame_start) begin
        ph = MRestart; rst_left = RstCycles; mq.delete(); run_left = 0; colour = '0;
        e_uf = 0; e_of = 0; quiet = 0;
      end else begin
        if (ph == MRestart) begin
          rst_left--;
          if (rst_left == 0) ph = MPrime;
        end else if (ph == MPrime) begin
          if (mq.size() >= 2 || (bus.display_on && !disp_prev)) ph = MRun;
        end else if (ph == MRun && bus.display_on) begin
          if (run_left > 0) begin
            e_rgb = colour;
            run_left--;
          end else if (mq.size() == 0) begin
            e_uf = 1;
          end else begin
            h = mq.pop_front();
            if (h[13:0] == 0) begin
              e_done = 1;
              ph = MEof;
            end else begin
              colour   = h[19:14];
              run_left = int'(h[13:0]) - 1;
              e_rgb    = colour;
            end
          end
        end
        if (accept) begin
          if (mq.size() < Depth) mq.push_back(bus.instr_in);
          else e_of = 1;
        end
        if (fl_now && !bus.qspi_active) begin
          quiet++;
          if (quiet > 64) e_uf = 1;
        end else begin
          quiet = 0;
        end
      end
      fl_prev   = fl_now;
      disp_prev = bus.display_on;
    end
    e_flash = (ph == MPrime) || (ph == MRun);
    e_hold  = (mq.size() >= HoldLevel);
  endtask

  initial begin
    model_live = 0;
    forever begin
      @(posedge clk);
      model_step();
      model_live = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        chk("model flash_rst_n", bus.flash_rst_n, e_flash);
        chk("model stream_hold", bus.stream_hold, e_hold);
        chk("model pixel_rgb", bus.pixel_rgb, e_rgb);
        chk("model underflow", bus.underflow, e_uf);
        chk("model overflow", bus.overflow, e_of);
        chk("model frame_done", bus.frame_done, e_done);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [5:0] c, input logic [13:0] len);
    bus.instr_in    = {c, len};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  // Returns one cycle after flash_rst_n has gone high, when strobes are accepted.
  task automatic start_frame();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    chk("restart flash_rst_n c1", bus.flash_rst_n, 0);
    chk("restart underflow cleared", bus.underflow, 0);
    chk("restart overflow cleared", bus.overflow, 0);
    @(negedge clk);
    chk("restart flash_rst_n c2", bus.flash_rst_n, 0);
    @(negedge clk);
    chk("prime flash_rst_n", bus.flash_rst_n, 1);
    @(negedge clk);
  endtask

  task automatic wait_pixel(input string nm, input logic [5:0] exp);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (bus.pixel_rgb == 6'h00 && i < 40);
    chk(nm, bus.pixel_rgb, exp);
  endtask

  initial begin
    logic [4:0] hold_exp;
    logic [4:0] of_exp;
    logic [5:0] pexp;
    rst_n = 1'b0;
    bus.frame_start = 0; bus.display_on = 0; bus.instr_in = '0;
    bus.instr_valid = 0; bus.qspi_active = 1;
    cycles(3);
    chk("reset flash_rst_n", bus.flash_rst_n, 0);
    chk("reset stream_hold", bus.stream_hold, 0);
    chk("reset pixel_rgb", bus.pixel_rgb, 0);
    chk("reset underflow", bus.underflow, 0);
    chk("reset overflow", bus.overflow, 0);
    chk("reset frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    bus.display_on = 1;
    cycles(2);
    chk("idle flash_rst_n", bus.flash_rst_n, 0);

    // Two runs, then starvation with display held on.
    start_frame();
    send(6'h3F, 14'd3);
    send(6'h05, 14'd2);
    wait_pixel("t1 pixel 1", 6'h3F);
    @(negedge clk); chk("t1 pixel 2", bus.pixel_rgb, 6'h3F);
    @(negedge clk); chk("t1 pixel 3", bus.pixel_rgb, 6'h3F);
    @(negedge clk); chk("t1 pixel 4", bus.pixel_rgb, 6'h05);
    @(negedge clk); chk("t1 pixel 5", bus.pixel_rgb, 6'h05);
    @(negedge clk); chk("t1 empty pixel", bus.pixel_rgb, 6'h00);
    chk("t1 underflow set", bus.underflow, 1);
    cycles(3);
    chk("t1 underflow sticky", bus.underflow, 1);

    // End-of-frame marker after a run of 4.
    start_frame();
    send(6'h2A, 14'd4);
    send(6'h00, 14'd0);
    wait_pixel("t2 pixel 1", 6'h2A);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); chk("t2 run pixel", bus.pixel_rgb, 6'h2A);
    end
    @(negedge clk);
    chk("t2 marker pixel", bus.pixel_rgb, 6'h00);
    chk("t2 frame_done", bus.frame_done, 1);
    chk("t2 eof flash_rst_n", bus.flash_rst_n, 0);
    @(negedge clk); chk("t2 frame_done single", bus.frame_done, 0);
    for (int i = 0; i < 6; i++) send(6'h3F, 14'd5);
    chk("t2 eof no overflow", bus.overflow, 0);
    chk("t2 eof no hold", bus.stream_hold, 0);

    // Fill the FIFO with display off: hold at count 3, overflow on the 5th.
    bus.display_on = 0;
    start_frame();
    hold_exp = 5'b11100;
    of_exp   = 5'b10000;
    for (int k = 0; k < 5; k++) begin
      send(6'(k + 1), 14'd1);
      chk("t4 stream_hold", bus.stream_hold, hold_exp[k]);
      chk("t4 overflow", bus.overflow, of_exp[k]);
    end

    // Full FIFO with simultaneous pop and write.
    start_frame();
    for (int k = 0; k < 4; k++) send(6'(k + 1), 14'd1);
    chk("t4b full hold", bus.stream_hold, 1);
    bus.display_on  = 1;
    bus.instr_in    = {6'h07, 14'd1};
    bus.instr_valid = 1;
    @(negedge clk);
    bus.instr_valid = 0;
    bus.display_on  = 0;
    chk("t4b pop+write no overflow", bus.overflow, 0);
    chk("t4b popped colour", bus.pixel_rgb, 6'h01);
    chk("t4b still full", bus.stream_hold, 1);

    // Run of 10 split by 5 blanking cycles after pixel 6.
    start_frame();
    send(6'h11, 14'd10);
    send(6'h22, 14'd1);
    cycles(2);
    for (int i = 0; i < 16; i++) begin
      bus.display_on = !(i >= 6 && i <= 10);
      if (i == 15) pexp = 6'h22;
      else if (i < 6 || i >= 11) pexp = 6'h11;
      else pexp = 6'h00;
      @(negedge clk);
      chk("t5 split run pixel", bus.pixel_rgb, pexp);
    end

    // frame_start mid-run: old colours must never reappear.
    start_frame();
    send(6'h33, 14'd20);
    send(6'h0C, 14'd5);
    wait_pixel("t6 old pixel", 6'h33);
    cycles(2);
    bus.frame_start = 1;
    @(negedge clk);
    bus.frame_start = 0;
    chk("t6 restart pixel black", bus.pixel_rgb, 6'h00);
    chk("t6 restart flash_rst_n", bus.flash_rst_n, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6 no stale colour", bus.pixel_rgb == 6'h33 || bus.pixel_rgb == 6'h0C, 0);
      chk("t6 fifo flushed", bus.stream_hold, 0);
    end
    send(6'h15, 14'd2);
    send(6'h2A, 14'd1);
    wait_pixel("t6 new pixel 1", 6'h15);
    @(negedge clk); chk("t6 new pixel 2", bus.pixel_rgb, 6'h15);
    @(negedge clk); chk("t6 new pixel 3", bus.pixel_rgb, 6'h2A);
    @(negedge clk); chk("t6 after runs", bus.pixel_rgb, 6'h00);

    // Reader silent: 64 quiet cycles tolerated, the 65th flags underflow.
    bus.display_on  = 0;
    bus.qspi_active = 0;
    start_frame();
    cycles(63);
    chk("wd 64 quiet cycles", bus.underflow, 0);
    @(negedge clk);
    chk("wd 65th quiet cycle", bus.underflow, 1);
    bus.qspi_active = 1;

    // Reset mid-frame.
    bus.display_on = 1;
    start_frame();
    send(6'h3F, 14'd8);
    send(6'h3F, 14'd8);
    wait_pixel("rst run pixel", 6'h3F);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst pixel black", bus.pixel_rgb, 6'h00);
    chk("rst flash_rst_n", bus.flash_rst_n, 0);
    rst_n = 1'b1;
    cycles(3);
    chk("rst idle pixel", bus.pixel_rgb, 6'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
